reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  Multi-ported general-purpose register file for the processor core.
//  READ independent combinational read ports serve the fetch/decode side;
//  WRITE independent synchronous write ports serve the backend.
//  Optionally hardwires entry 0 to zero (RISC-style zero register).
// PARAMETERS
//  DATA      32  width of one register in bits
//  ADDR      5   address width; DEPTH = 2**ADDR entries (32 by default)
//  READ      4   number of read ports
//  WRITE     4   number of write ports
//  ZERO_REG  1   1 = entry 0 always reads 0 and ignores writes; 0 = normal entry
// PORTS
//  clk    in   1           clock; all state updates on the rising edge
//  reset  in   1           synchronous, active-high reset
//  raddr  in   ADDR*READ   read addresses; port p uses raddr[p*ADDR +: ADDR]
//  rdata  out  DATA*READ   read data; port p drives rdata[p*DATA +: DATA]
//  waddr  in   ADDR*WRITE  write addresses; port w uses waddr[w*ADDR +: ADDR]
//  wdata  in   DATA*WRITE  write data; port w uses wdata[w*DATA +: DATA]
//  we_    in   WRITE       write enables, active-low; we_[w]=0 writes port w
// BEHAVIOUR
//  - Storage: array regs[0:DEPTH-1] of DATA bits. The name regs is fixed so
//    benches can dump it hierarchically.
//  - Reset: while reset=1 at a rising edge, every entry becomes 0.
//    Reset has priority over all writes in that cycle.
//  - Write: at the rising edge, for each w with we_[w]=0:
//    regs[waddr_w] <= wdata_w. Latency is one cycle.
//  - Same-address collision (two enabled ports, same address): the
//    highest-numbered port wins. Writes to different addresses all commit.
//  - Read: purely combinational, zero latency. Each port is independent;
//    any number of ports may read the same address.
//  - Read of an address written in the same cycle returns the old value
//    (unless REGFILE_BYPASS_EN is defined).
//  - ZERO_REG=1: writes to address 0 are discarded, and rdata for address 0
//    is forced to 0 regardless of storage. Other ports' writes in the same
//    cycle are unaffected.
//  - ZERO_REG=0: entry 0 behaves like any other entry.
//  - No X-propagation: outputs after reset are fully defined (all 0).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled.
//    If an enabled write port targets raddr_p in the current cycle, rdata_p
//    returns that wdata combinationally. The same highest-port-wins rule
//    applies.
//    The zero register is still never forwarded; it always reads 0.
//    Forwarding is suppressed while reset=1.
//  REGFILE_BYPASS_EN undefined: rdata reflects stored contents only.
// STRUCTURE
//  - Shared package reg_file_pkg holds the default constants
//    (DATA_W=32, ADDR_W=5, READ_N=4, WRITE_N=4) and the macros
//    Enable/Disable_ (active-low helper).
//  - One sub-module, reg_file_wsel: per-entry write-select priority encoder.
//    Inputs: waddr, we_ and the entry index.
//    Outputs: the hit flag and the index of the winning port.
//    It is reused for the bypass match per read port.
//  - Top level contains the array, the reset/write loop and the read muxes
//    (generate over READ).
// TESTING
//  1 reset held 1 cycle, then read all ports at addr 0..3 -> every rdata = 0.
//  2 write all ports (31,31),(1,1),(2,2),(3,3), we_=4'b0000 ->
//    regs[31]=31, regs[1]=1, regs[2]=2, regs[3]=3 next cycle.
//  3 ZERO_REG=1: port0 writes 0xdeadbeef to addr 0, we_=4'b1110 ->
//    regs[0]/rdata for raddr=0 stays 0; other ports idle, no change.
//  4 raddr ports = {31,1,3,2} (port3..0) ->
//    rdata = {31,1,3,2} combinationally, same cycle.
//  5 write (31,31),(4,0x10),(5,0x20),(6,0x30) while reading 2,3,1,31 ->
//    reads unchanged (2,3,1,31) before the edge; after the edge
//    regs[4..6]=0x10,0x20,0x30.
//  6 ports 1 and 3 write addr 7 with 0xA / 0xB in the same cycle ->
//    regs[7]=0xB. With REGFILE_BYPASS_EN defined, raddr=7 reads 0xB in
//    that same cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file.
// Enable/Disable_ give readable names to the active-low write-enable levels.
package reg_file_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int READ_N  = 4;
  localparam int WRITE_N = 4;

  // Width of a write-port index; at least one bit even for a single port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

`ifndef Enable
`define Enable 1'b0
`endif
`ifndef Disable_
`define Disable_ 1'b1
`endif

// File: rtl/reg_file_wsel.sv
// Write-select priority encoder: flags whether any enabled write port targets idx
// and returns the winning port; the highest-numbered matching port wins.
module reg_file_wsel
  import reg_file_pkg::*;
#(
  parameter int ADDR  = ADDR_W,
  parameter int WRITE = WRITE_N,
  parameter int SELW  = sel_w(WRITE)
) (
  input  logic [ADDR*WRITE-1:0] waddr,
  input  logic [WRITE-1:0]      we_,
  input  logic [ADDR-1:0]       idx,
  output logic                  hit,
  output logic [SELW-1:0]       sel
);

  // Ascending scan so a later (higher) port overrides an earlier match.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int w = 0; w < WRITE; w++) begin
      if (we_[w] == `Enable && waddr[w*ADDR +: ADDR] == idx) begin
        hit = 1'b1;
        sel = w[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Multi-ported register file: combinational reads, one-cycle synchronous writes.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA     = DATA_W,
  parameter int ADDR     = ADDR_W,
  parameter int READ     = READ_N,
  parameter int WRITE    = WRITE_N,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR*READ-1:0]  raddr,
  output logic [DATA*READ-1:0]  rdata,
  input  logic [ADDR*WRITE-1:0] waddr,
  input  logic [DATA*WRITE-1:0] wdata,
  input  logic [WRITE-1:0]      we_
);

  localparam int DEPTH = 2 ** ADDR;
  localparam int SELW  = sel_w(WRITE);

  logic [DATA-1:0] regs   [0:DEPTH-1];
  logic [DATA-1:0] regs_d [0:DEPTH-1];
  logic            wr_hit [0:DEPTH-1];
  logic [SELW-1:0] wr_sel [0:DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    reg_file_wsel #(.ADDR(ADDR), .WRITE(WRITE), .SELW(SELW)) u_wsel (
      .waddr (waddr),
      .we_   (we_),
      .idx   (i[ADDR-1:0]),
      .hit   (wr_hit[i]),
      .sel   (wr_sel[i])
    );

    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign regs_d[i] = '0;
    end else begin : g_norm
      assign regs_d[i] = wr_hit[i] ? wdata[int'(wr_sel[i])*DATA +: DATA] : regs[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) regs[i] <= '0;
      else       regs[i] <= regs_d[i];
    end
  end

  for (genvar p = 0; p < READ; p++) begin : g_rd
    logic [ADDR-1:0] ra;
    logic [DATA-1:0] rd;
    assign ra = raddr[p*ADDR +: ADDR];

`ifdef REGFILE_BYPASS_EN
    logic            byp_hit;
    logic [SELW-1:0] byp_sel;
    reg_file_wsel #(.ADDR(ADDR), .WRITE(WRITE), .SELW(SELW)) u_byp (
      .waddr (waddr),
      .we_   (we_),
      .idx   (ra),
      .hit   (byp_hit),
      .sel   (byp_sel)
    );
`endif

    always_comb begin
      rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
      if (!reset && byp_hit) rd = wdata[int'(byp_sel)*DATA +: DATA];
`endif
      // Zero register overrides both storage and forwarding.
      if (ZERO_REG != 0 && ra == '0) rd = '0;
    end

    assign rdata[p*DATA +: DATA] = rd;
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file: array model updated per edge, compared on every negedge,
// plus directed cases with literal expectations.
module tb_reg_file;
  localparam int D = 32, A = 5, R = 4, W = 4, DEPTH = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [A*R-1:0] raddr;
  logic [D*R-1:0] rdata;
  logic [A*W-1:0] waddr;
  logic [D*W-1:0] wdata;
  logic [W-1:0]   we_;

  int checks = 0;
  int failures = 0;
  logic [D-1:0] model [DEPTH];
  bit model_valid = 1'b0;

  reg_file #(.DATA(D), .ADDR(A), .READ(R), .WRITE(W), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .raddr (raddr),
    .rdata (rdata),
    .waddr (waddr),
    .wdata (wdata),
    .we_   (we_)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // What a read port must show right now, from the stored model and current inputs.
  function automatic logic [D-1:0] expect_read(input int a);
    logic [D-1:0] v;
    if (a == 0) return '0;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    if (!reset)
      for (int w = 0; w < W; w++)
        if (!we_[w] && int'(waddr[w*A +: A]) == a) v = wdata[w*D +: D];
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      model_valid = 1'b1;
    end else begin
      for (int w = 0; w < W; w++)
        if (!we_[w] && waddr[w*A +: A] != 0) model[waddr[w*A +: A]] = wdata[w*D +: D];
    end
  end

  always @(negedge clk) begin
    if (model_valid)
      for (int p = 0; p < R; p++)
        check($sformatf("model_rd%0d", p), rdata[p*D +: D], expect_read(int'(raddr[p*A +: A])));
  end

  function automatic logic [D-1:0] port(input int p);
    return rdata[p*D +: D];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we_ = '1; raddr = '0; waddr = '0; wdata = '0;
    next_cycle();
    reset = 1'b0;
    raddr = {5'd3, 5'd2, 5'd1, 5'd0};
    @(negedge clk);
    for (int p = 0; p < R; p++) check($sformatf("reset_rd%0d", p), port(p), 32'd0);

    // Four writes on four ports.
    next_cycle();
    waddr = {5'd3, 5'd2, 5'd1, 5'd31};
    wdata = {32'd3, 32'd2, 32'd1, 32'd31};
    we_   = 4'b0000;
    next_cycle();
    we_   = 4'b1111;
    raddr = {5'd3, 5'd2, 5'd1, 5'd31};
    @(negedge clk);
    check("wr_31", port(0), 32'd31);
    check("wr_1",  port(1), 32'd1);
    check("wr_2",  port(2), 32'd2);
    check("wr_3",  port(3), 32'd3);

    // Zero register ignores writes and is never forwarded.
    next_cycle();
    waddr = '0;
    wdata = {32'd0, 32'd0, 32'd0, 32'hdeadbeef};
    we_   = 4'b1110;
    raddr = '0;
    @(negedge clk);
    check("zero_same", port(0), 32'd0);
    next_cycle();
    we_ = 4'b1111;
    @(negedge clk);
    check("zero_after", port(0), 32'd0);

    // Mixed read addresses, combinational.
    raddr = {5'd31, 5'd1, 5'd3, 5'd2};
    #1;
    check("rd_mix0", port(0), 32'd2);
    check("rd_mix1", port(1), 32'd3);
    check("rd_mix2", port(2), 32'd1);
    check("rd_mix3", port(3), 32'd31);

    // Reads during writes to other addresses see the old contents.
    next_cycle();
    waddr = {5'd6, 5'd5, 5'd4, 5'd31};
    wdata = {32'h30, 32'h20, 32'h10, 32'd31};
    we_   = 4'b0000;
    raddr = {5'd31, 5'd1, 5'd3, 5'd2};
    @(negedge clk);
    check("rd_during_wr0", port(0), 32'd2);
    check("rd_during_wr3", port(3), 32'd31);
    next_cycle();
    we_   = 4'b1111;
    raddr = {5'd0, 5'd6, 5'd5, 5'd4};
    @(negedge clk);
    check("wr_4", port(0), 32'h10);
    check("wr_5", port(1), 32'h20);
    check("wr_6", port(2), 32'h30);

    // Collision: port 3 beats port 1 on address 7.
    next_cycle();
    waddr = {5'd7, 5'd0, 5'd7, 5'd0};
    wdata = {32'hB, 32'h0, 32'hA, 32'h0};
    we_   = 4'b0101;
    raddr = {5'd0, 5'd0, 5'd0, 5'd7};
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("byp_collide", port(0), 32'hB);
`else
    check("old_collide", port(0), 32'd0);
`endif
    next_cycle();
    we_ = 4'b1111;
    @(negedge clk);
    check("collide_7", port(0), 32'hB);

    // Randomized traffic; narrow address range some of the time to force collisions.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset = ($urandom_range(0, 99) == 0);
      we_   = W'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < W; k++)
        waddr[k*A +: A] = (n % 2 == 0) ? A'($urandom_range(0, 7)) : A'($urandom);
      for (int k = 0; k < R; k++)
        raddr[k*A +: A] = (n % 3 == 0) ? A'($urandom_range(0, 7)) : A'($urandom);
    end
    next_cycle();
    reset = 1'b0;
    we_   = '1;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
